ps2_scan_decoder: RTL and testbench



---
 rtl/ps2_scan_decoder_if.sv | 12 +
 rtl/ps2_scan_decoder.sv | 168 ++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_scan_decoder_if.sv
// Key-event bus from the PS/2 scan decoder to the game logic.
// The decoder drives it through the master modport; consumers use slave.
interface ps2_scan_decoder_if;
  logic       valid;
  logic       makeBreak;
  logic [7:0] outCode;
  logic       extended;
  logic       frame_err;

  modport master (output valid, output makeBreak, output outCode, output extended, output frame_err);
  modport slave  (input  valid, input  makeBreak, input  outCode, input  extended, input  frame_err);
endinterface

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: conditions the raw pins, deframes 11-bit frames and
// folds the E0/F0 prefixes into single key events on the master modport.
//
// state | meaning
// IDLE  | waiting for a start bit (filtered clock fall with data low)
// RECV  | shifting D0..D7, parity and stop; timeout counter running
// CHECK | one cycle to validate parity/stop and hand the byte on
module ps2_scan_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  ps2_scan_decoder_if.master  evt
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  state_t        state_q, state_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [9:0]    sr_q, sr_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          brk_q, brk_d, ext_q, ext_d;
  logic          valid_q, valid_d, make_brk_q, make_brk_d, extd_q, extd_d;
  logic [7:0]    out_code_q, out_code_d;
  logic          frame_err_q, frame_err_d;
  logic          fall, byte_ok, err;

  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    filt_d     = filt_q;
    filt_cnt_d = filt_cnt_q;
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    sr_d       = sr_q;
    to_cnt_d   = to_cnt_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    valid_d    = 1'b0;
    make_brk_d = make_brk_q;
    extd_d     = extd_q;
    out_code_d = out_code_q;
    frame_err_d = 1'b0;
    byte_ok    = 1'b0;
    err        = 1'b0;

    // Counter tracks how long the synchronized clock has disagreed with the filtered one.
    if (clk_s2_q == filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FILT_LAST) begin
      filt_d     = clk_s2_q;
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end
    fall = filt_q & ~filt_d;

    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (fall && !dat_s2_q) begin
          state_d  = RECV;
          bitcnt_d = '0;
        end
      end
      RECV: begin
        if (fall) begin
          to_cnt_d = '0;
          sr_d     = {dat_s2_q, sr_q[9:1]};
          if (bitcnt_q == 4'd9) state_d = CHECK;
          else                  bitcnt_d = bitcnt_q + 1'b1;
        end else if (to_cnt_q == TO_LAST) begin
          err      = 1'b1;
          to_cnt_d = '0;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        if ((^sr_q[8:0]) && sr_q[9]) byte_ok = 1'b1;
        else                         err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (err) begin
      frame_err_d = 1'b1;
      brk_d       = 1'b0;
      ext_d       = 1'b0;
    end else if (byte_ok) begin
      if (sr_q[7:0] == 8'hE0) begin
        ext_d = 1'b1;
      end else if (sr_q[7:0] == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        valid_d    = 1'b1;
        out_code_d = sr_q[7:0];
        make_brk_d = ~brk_q;
        extd_d     = ext_q;
        brk_d      = 1'b0;
        ext_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      sr_q        <= '0;
      to_cnt_q    <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      valid_q     <= 1'b0;
      make_brk_q  <= 1'b0;
      extd_q      <= 1'b0;
      out_code_q  <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      sr_q        <= sr_d;
      to_cnt_q    <= to_cnt_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      valid_q     <= valid_d;
      make_brk_q  <= make_brk_d;
      extd_q      <= extd_d;
      out_code_q  <= out_code_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign evt.valid     = valid_q;
  assign evt.makeBreak = make_brk_q;
  assign evt.outCode   = out_code_q;
  assign evt.extended  = extd_q;
  assign evt.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: expected key events are queued as
// frames are sent and checked when valid pulses appear.
`timescale 1ns/1ps
module tb_ps2_scan_decoder;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 200;
  // stop edge -> 2 sync flops -> FILTER_LEN samples -> CHECK -> output register
  localparam int LAT = 2 + FILTER_LEN + 1;

  typedef struct {
    logic [7:0] code;
    logic       mb;
    logic       ext;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk;
  logic ps2_data;

  ps2_scan_decoder_if evt ();

  ps2_scan_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .evt      (evt)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_fall_cyc = 0;
  int   err_seen = 0;
  int   exp_err = 0;
  logic prev_valid = 1'b0;
  logic prev_err = 1'b0;
  ev_t  sb_q[$];
  ev_t  got;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic mb, input logic ext);
    ev_t e;
    e.code = code;
    e.mb   = mb;
    e.ext  = ext;
    sb_q.push_back(e);
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (9) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
    ps2_data = 1'b1;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      if (evt.valid) begin
        check_eq("v_width", 32'(prev_valid), 0);
        check_eq("v_excl", 32'(evt.frame_err), 0);
        check_eq("latency", cyc - last_fall_cyc, LAT);
        check_eq("sb_nonempty", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          got = sb_q.pop_front();
          check_eq("outCode", 32'(evt.outCode), 32'(got.code));
          check_eq("makeBreak", 32'(evt.makeBreak), 32'(got.mb));
          check_eq("extended", 32'(evt.extended), 32'(got.ext));
        end
      end
      if (evt.frame_err) begin
        err_seen++;
        check_eq("e_width", 32'(prev_err), 0);
      end
    end
    prev_valid = evt.valid;
    prev_err   = evt.frame_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst_valid", 32'(evt.valid), 0);
    check_eq("rst_mb", 32'(evt.makeBreak), 0);
    check_eq("rst_code", 32'(evt.outCode), 0);
    check_eq("rst_ext", 32'(evt.extended), 0);
    check_eq("rst_err", 32'(evt.frame_err), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // 1: plain make
    expect_ev(8'h1D, 1'b1, 1'b0);
    send_frame(8'h1D, 1'b0, 11);
    repeat (20) @(negedge clk);
    check_eq("t1_errs", err_seen, exp_err);

    // 2: break
    send_frame(8'hF0, 1'b0, 11);
    expect_ev(8'h1D, 1'b0, 1'b0);
    send_frame(8'h1D, 1'b0, 11);

    // 3: extended break then plain make
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    expect_ev(8'h75, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 11);
    expect_ev(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 11);

    // 4: parity error, outputs hold
    exp_err++;
    send_frame(8'h23, 1'b1, 11);
    repeat (20) @(negedge clk);
    check_eq("t4_errs", err_seen, exp_err);
    check_eq("t4_hold_code", 32'(evt.outCode), 32'h1C);
    check_eq("t4_hold_mb", 32'(evt.makeBreak), 1);
    check_eq("t4_hold_ext", 32'(evt.extended), 0);
    expect_ev(8'h23, 1'b1, 1'b0);
    send_frame(8'h23, 1'b0, 11);

    // 5: timeout mid-frame clears pending break
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h1B, 1'b0, 5);
    exp_err++;
    repeat (250) @(negedge clk);
    check_eq("t5_errs", err_seen, exp_err);
    check_eq("t5_hold_code", 32'(evt.outCode), 32'h23);
    expect_ev(8'h1B, 1'b1, 1'b0);
    send_frame(8'h1B, 1'b0, 11);

    // 6a: short clock glitch with data low must not start a frame
    @(negedge clk);
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk  = 1'b1;
    repeat (5) @(negedge clk);
    ps2_data = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("t6_glitch_errs", err_seen, exp_err);
    check_eq("t6_glitch_sb", sb_q.size(), 0);

    // 6b: reset mid-frame discards partial data and the pending E0
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h55, 1'b0, 5);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_valid", 32'(evt.valid), 0);
    check_eq("t6_rst_mb", 32'(evt.makeBreak), 0);
    check_eq("t6_rst_code", 32'(evt.outCode), 0);
    check_eq("t6_rst_ext", 32'(evt.extended), 0);
    check_eq("t6_rst_err", 32'(evt.frame_err), 0);
    expect_ev(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 11);

    repeat (20) @(negedge clk);
    check_eq("final_sb_empty", sb_q.size(), 0);
    check_eq("final_errs", err_seen, exp_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
